lii_link_fifo: RTL and testbench

LII_LINK_FIFO -- requirements
Module: lii_link_fifo

---
 rtl/lii_pkg.sv | 25 ++
 rtl/lii_fifo_ram.sv | 35 +++
 rtl/lii_link_fifo.sv | 136 +++++++++++++
 tb/tb_lii_link_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lii_pkg.sv
// Shared LII link definitions: node ID width, sideband and beat layouts.
package lii_pkg;

  localparam int LII_ID_W   = 8;
  localparam int LII_PW_DEF = 1024;

  typedef logic [LII_ID_W-1:0] lii_id_t;

  typedef struct packed {
    lii_id_t src;
    lii_id_t dst;
  } lii_side_t;

  typedef struct packed {
    logic [LII_PW_DEF-1:0] data;
    lii_id_t               src;
    lii_id_t               dst;
  } lii_beat_t;

  // Stored width of one beat of a given data width (data + src + dst).
  function automatic int lii_beat_bits(input int pw);
    return pw + 2 * LII_ID_W;
  endfunction

endpackage

// File: rtl/lii_fifo_ram.sv
// Simple dual-port beat storage with a registered read port.
// Same-address write and read on one edge returns the new data (write-first).
module lii_fifo_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The bypass lets a beat written into an empty FIFO appear at the head one edge later.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lii_link_fifo.sv
// LII link FIFO: DEPTH-beat elastic buffer carrying beat data plus src/dst node IDs.
// Defining LII_FIFO_STATS_EN adds the beats_out / max_level statistics outputs.
module lii_link_fifo
  import lii_pkg::*;
#(
  parameter int PW        = LII_PW_DEF,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic [PW-1:0]          lii_in_tdata,
  input  logic                   lii_in_tvalid,
  output logic                   lii_in_tready,
  input  logic [LII_ID_W-1:0]    lii_in_src,
  input  logic [LII_ID_W-1:0]    lii_in_dst,
  output logic [PW-1:0]          lii_out_tdata,
  output logic                   lii_out_tvalid,
  input  logic                   lii_out_tready,
  output logic [LII_ID_W-1:0]    lii_out_src,
  output logic [LII_ID_W-1:0]    lii_out_dst,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full
`ifdef LII_FIFO_STATS_EN
  ,
  output logic [31:0]            beats_out,
  output logic [$clog2(DEPTH):0] max_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = lii_beat_bits(PW);
  localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);

  typedef struct packed {
    logic [PW-1:0] data;
    lii_id_t       src;
    lii_id_t       dst;
  } beat_t;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        in_rdy_q, in_rdy_d;
  logic        out_vld_q, out_vld_d;
  logic        af_q, af_d;
  logic        full_d, empty_d;
  logic        push, pop;
  beat_t       wr_beat, rd_beat;

  assign push = lii_in_tvalid & in_rdy_q;
  assign pop  = lii_out_tready & out_vld_q;

  // Pointers carry one extra MSB so equal indices can be told apart as full or empty.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
    level_d   = wr_ptr_d - rd_ptr_d;
    empty_d   = (wr_ptr_d == rd_ptr_d);
    full_d    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    in_rdy_d  = !full_d;
    out_vld_d = !empty_d;
    af_d      = (level_d >= AF_LEVEL);
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
      af_q      <= af_d;
    end
  end

  always_comb begin
    wr_beat      = '0;
    wr_beat.data = lii_in_tdata;
    wr_beat.src  = lii_in_src;
    wr_beat.dst  = lii_in_dst;
  end

  // Reading at the next read pointer keeps the RAM output equal to the current head.
  lii_fifo_ram #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_beat),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (rd_beat)
  );

  assign lii_in_tready  = in_rdy_q;
  assign lii_out_tvalid = out_vld_q;
  assign lii_out_tdata  = rd_beat.data;
  assign lii_out_src    = rd_beat.src;
  assign lii_out_dst    = rd_beat.dst;
  assign level          = level_q;
  assign almost_full    = af_q;

`ifdef LII_FIFO_STATS_EN
  logic [31:0] beats_q, beats_d;
  logic [AW:0] max_q, max_d;

  always_comb begin
    beats_d = beats_q + {31'd0, pop};
    max_d   = (level_d > max_q) ? level_d : max_q;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      beats_q <= '0;
      max_q   <= '0;
    end else begin
      beats_q <= beats_d;
      max_q   <= max_d;
    end
  end

  assign beats_out = beats_q;
  assign max_level = max_q;
`endif

endmodule

// File: tb/tb_lii_link_fifo.sv
// Self-checking bench for lii_link_fifo: directed vector table, queue-model random
// traffic, mid-transfer reset, and (with LII_FIFO_STATS_EN) the statistics outputs.
module tb_lii_link_fifo;

  localparam int PW        = 32;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int NBEATS    = 1000;
  localparam int MAXCYC    = 20000;

  logic          aclk;
  logic          arstn;
  logic [PW-1:0] inData;
  logic          inValid;
  logic          inReady;
  logic [7:0]    inSrc;
  logic [7:0]    inDst;
  logic [PW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic [7:0]    outSrc;
  logic [7:0]    outDst;
  logic [LW-1:0] level;
  logic          almostFull;
`ifdef LII_FIFO_STATS_EN
  logic [31:0]   beatsOut;
  logic [LW-1:0] maxLevel;
`endif

  lii_link_fifo #(
    .PW        (PW),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .aclk           (aclk),
    .arstn          (arstn),
    .lii_in_tdata   (inData),
    .lii_in_tvalid  (inValid),
    .lii_in_tready  (inReady),
    .lii_in_src     (inSrc),
    .lii_in_dst     (inDst),
    .lii_out_tdata  (outData),
    .lii_out_tvalid (outValid),
    .lii_out_tready (outReady),
    .lii_out_src    (outSrc),
    .lii_out_dst    (outDst),
    .level          (level),
    .almost_full    (almostFull)
`ifdef LII_FIFO_STATS_EN
    ,
    .beats_out      (beatsOut),
    .max_level      (maxLevel)
`endif
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    logic [PW-1:0] data;
    logic [7:0]    src;
    logic [7:0]    dst;
  } beat_t;

  typedef struct {
    logic          inValid;
    logic [PW-1:0] data;
    logic [7:0]    src;
    logic [7:0]    dst;
    logic          outReady;
    logic          expValid;
    int            expLevel;
    logic          expReady;
    logic          expAf;
    logic [PW-1:0] expData;
    logic [7:0]    expSrc;
    logic [7:0]    expDst;
  } vec_t;

  int    compared   = 0;
  int    mismatched = 0;
  beat_t modelQ[$];
  bit    modelArmed = 1'b0;
  int    statDelivered = 0;
  int    statPeak = 0;
  vec_t  vecs[$];

  task automatic checkValue(input string name, input logic [63:0] actual,
                            input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic modelReady();
    return modelArmed && (modelQ.size() < DEPTH);
  endfunction

  // Drive one cycle from a negedge; the model follows the FIFO rules at the posedge.
  task automatic applyStimulus(input logic v, input logic [PW-1:0] d, input logic [7:0] s,
                               input logic [7:0] ds, input logic r, output logic accepted);
    beat_t b;
    logic  popped;
    inValid  = v;
    inData   = d;
    inSrc    = s;
    inDst    = ds;
    outReady = r;
    @(posedge aclk);
    accepted = v && modelReady();
    popped   = r && (modelQ.size() > 0);
    if (popped) begin
      modelQ.delete(0);
      statDelivered++;
    end
    if (accepted) begin
      b.data = d;
      b.src  = s;
      b.dst  = ds;
      modelQ.push_back(b);
    end
    if (modelQ.size() > statPeak) statPeak = modelQ.size();
    modelArmed = 1'b1;
    @(negedge aclk);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_tvalid"}, 64'(outValid), 64'(modelQ.size() > 0));
    checkValue({tag, "_level"}, 64'(level), 64'(modelQ.size()));
    checkValue({tag, "_tready"}, 64'(inReady), 64'(modelReady()));
    checkValue({tag, "_almost_full"}, 64'(almostFull),
               64'(modelQ.size() >= DEPTH - AF_MARGIN));
    if (modelQ.size() > 0) begin
      checkValue({tag, "_data"}, 64'(outData), 64'(modelQ[0].data));
      checkValue({tag, "_src"}, 64'(outSrc), 64'(modelQ[0].src));
      checkValue({tag, "_dst"}, 64'(outDst), 64'(modelQ[0].dst));
    end
  endtask

  task automatic addVec(input logic v, input logic [PW-1:0] d, input logic [7:0] s,
                        input logic [7:0] ds, input logic r, input logic ev, input int el,
                        input logic er, input logic eaf, input logic [PW-1:0] ed,
                        input logic [7:0] es, input logic [7:0] eds);
    vec_t row;
    row.inValid = v;  row.data = d;  row.src = s;  row.dst = ds;  row.outReady = r;
    row.expValid = ev;  row.expLevel = el;  row.expReady = er;  row.expAf = eaf;
    row.expData = ed;  row.expSrc = es;  row.expDst = eds;
    vecs.push_back(row);
  endtask

  task automatic resetDut();
    inValid  = 1'b0;
    outReady = 1'b0;
    inData   = '0;
    inSrc    = '0;
    inDst    = '0;
    arstn    = 1'b0;
    modelQ.delete();
    modelArmed    = 1'b0;
    statDelivered = 0;
    statPeak      = 0;
    repeat (2) @(negedge aclk);
    arstn = 1'b1;
  endtask

  initial begin
    logic  acc;
    string tag;
    int    txCount, rxCount, cycles;
    logic  v, r;

    // Directed table: single beat, fill to full, pop-while-full, drain in order.
    addVec(1'b0, '0, 8'd0, 8'd0, 1'b0, 1'b0, 0, 1'b1, 1'b0, '0, 8'd0, 8'd0);
    addVec(1'b1, 32'hA5, 8'd1, 8'd2, 1'b0, 1'b1, 1, 1'b1, 1'b0, 32'hA5, 8'd1, 8'd2);
    addVec(1'b0, '0, 8'd0, 8'd0, 1'b1, 1'b0, 0, 1'b1, 1'b0, '0, 8'd0, 8'd0);
    for (int i = 0; i < DEPTH; i++) begin
      addVec(1'b1, 32'h100 + PW'(i), 8'(i), 8'(15 - i), 1'b0, 1'b1, i + 1,
             (i + 1) < DEPTH, (i + 1) >= 14, 32'h100, 8'd0, 8'd15);
    end
    addVec(1'b1, 32'h999, 8'hEE, 8'hEE, 1'b1, 1'b1, 15, 1'b1, 1'b1, 32'h101, 8'd1, 8'd14);
    addVec(1'b0, '0, 8'd0, 8'd0, 1'b0, 1'b1, 15, 1'b1, 1'b1, 32'h101, 8'd1, 8'd14);
    for (int j = 1; j <= 15; j++) begin
      addVec(1'b0, '0, 8'd0, 8'd0, 1'b1, (15 - j) > 0, 15 - j, 1'b1, (15 - j) >= 14,
             32'h101 + PW'(j), 8'(1 + j), 8'(14 - j));
    end

    inValid  = 1'b0;
    outReady = 1'b0;
    inData   = '0;
    inSrc    = '0;
    inDst    = '0;
    arstn    = 1'b0;
    #3;
    checkOutput("reset");
    @(negedge aclk);
    arstn = 1'b1;
    checkValue("tready_before_first_edge", 64'(inReady), 64'd0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].inValid, vecs[k].data, vecs[k].src, vecs[k].dst,
                    vecs[k].outReady, acc);
      tag = $sformatf("vec%0d", k);
      checkOutput(tag);
      checkValue({tag, "_exp_tvalid"}, 64'(outValid), 64'(vecs[k].expValid));
      checkValue({tag, "_exp_level"}, 64'(level), 64'(vecs[k].expLevel));
      checkValue({tag, "_exp_tready"}, 64'(inReady), 64'(vecs[k].expReady));
      checkValue({tag, "_exp_af"}, 64'(almostFull), 64'(vecs[k].expAf));
      if (vecs[k].expValid) begin
        checkValue({tag, "_exp_data"}, 64'(outData), 64'(vecs[k].expData));
        checkValue({tag, "_exp_src"}, 64'(outSrc), 64'(vecs[k].expSrc));
        checkValue({tag, "_exp_dst"}, 64'(outDst), 64'(vecs[k].expDst));
      end
    end

    // Random traffic: 1000 incrementing beats must come out as 0..999.
    txCount = 0;
    rxCount = 0;
    cycles  = 0;
    while (rxCount < NBEATS && cycles < MAXCYC) begin
      v = (txCount < NBEATS) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      if (r && modelQ.size() > 0) begin
        checkValue("rx_order", 64'(outData), 64'(rxCount));
        rxCount++;
      end
      applyStimulus(v, PW'(txCount), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), r, acc);
      if (acc) txCount++;
      checkOutput("rand");
      cycles++;
    end
    checkValue("rx_count", 64'(rxCount), 64'(NBEATS));

    // Reset with seven beats buffered: outputs clear at once, tready returns after one edge.
    resetDut();
    applyStimulus(1'b0, '0, 8'd0, 8'd0, 1'b0, acc);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 32'h700 + PW'(i), 8'd7, 8'd7, 1'b0, acc);
    end
    checkOutput("pre_reset");
    #2;
    inValid  = 1'b0;
    outReady = 1'b0;
    arstn    = 1'b0;
    modelQ.delete();
    modelArmed = 1'b0;
    #1;
    checkValue("mid_reset_tvalid", 64'(outValid), 64'd0);
    checkValue("mid_reset_level", 64'(level), 64'd0);
    checkValue("mid_reset_tready", 64'(inReady), 64'd0);
    checkValue("mid_reset_af", 64'(almostFull), 64'd0);
    @(negedge aclk);
    arstn = 1'b1;
    checkValue("post_reset_tready_pre_edge", 64'(inReady), 64'd0);
    @(posedge aclk);
    #1;
    modelArmed = 1'b1;
    checkValue("post_reset_tready", 64'(inReady), 64'd1);
    checkValue("post_reset_level", 64'(level), 64'd0);
    checkValue("post_reset_tvalid", 64'(outValid), 64'd0);
    @(negedge aclk);
    applyStimulus(1'b1, 32'h55, 8'd3, 8'd4, 1'b0, acc);
    checkOutput("after_reset_push");
    checkValue("after_reset_head", 64'(outData), 64'h55);

`ifdef LII_FIFO_STATS_EN
    // 20 beats with the occupancy peaking at 9.
    resetDut();
    applyStimulus(1'b0, '0, 8'd0, 8'd0, 1'b0, acc);
    checkValue("stats_reset_beats", 64'(beatsOut), 64'd0);
    checkValue("stats_reset_max", 64'(maxLevel), 64'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, PW'(i), 8'd0, 8'd0, 1'b0, acc);
    for (int i = 9; i < 20; i++) applyStimulus(1'b1, PW'(i), 8'd0, 8'd0, 1'b1, acc);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, '0, 8'd0, 8'd0, 1'b1, acc);
    checkOutput("stats_end");
    checkValue("beats_out", 64'(beatsOut), 64'd20);
    checkValue("max_level", 64'(maxLevel), 64'd9);
    checkValue("beats_out_model", 64'(beatsOut), 64'(statDelivered));
    checkValue("max_level_model", 64'(maxLevel), 64'(statPeak));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
